// File: rtl/video_line_wr_ctrl_if.sv
// SDRAM controller write-port bundle: request/acknowledge handshake plus burst descriptor and data.
// The line writer drives the master side; the SDRAM controller takes the slave side.
interface video_line_wr_ctrl_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 22,
    parameter int unsigned LEN_W  = 9
) ();

    logic              wr_req;
    logic              wr_ack;
    logic [DATA_W-1:0] burst_data;
    logic [LEN_W-1:0]  burst_length;
    logic [ADDR_W-1:0] burst_address;

    modport master (
        output wr_req,
        output burst_data,
        output burst_length,
        output burst_address,
        input  wr_ack
    );

    modport slave (
        input  wr_req,
        input  burst_data,
        input  burst_length,
        input  burst_address,
        output wr_ack
    );

endinterface

// File: rtl/video_line_wr_ctrl.sv
// Video-line writer: drains the capture FIFO into SDRAM as row-aligned bursts with frame-buffer rotation.
// Optional macro FIELD_INTERLEAVE_EN interleaves odd/even fields into one progressive frame.
module video_line_wr_ctrl #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned ADDR_W       = 22,
    parameter int unsigned COL_W        = 8,
    parameter int unsigned LINE_PIX     = 720,
    parameter int unsigned BURST_MAX    = 256,
    parameter int unsigned FIFO_LVL_W   = 9,
    parameter int unsigned FRAME_BUFS   = 2,
    parameter int unsigned FRAME_ROW_SH = 11
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  vs_neg,
    input  logic                  vs,
    input  logic                  field,
    input  logic [FIFO_LVL_W-1:0] rdusedw_fifo,
    input  logic [DATA_W-1:0]     indata,
    output logic                  rd_en_fifo,
    video_line_wr_ctrl_if.master  wr_port,
    output logic [1:0]            wr_buf_idx,
    output logic                  frame_done
);

    localparam int unsigned BPL      = (LINE_PIX + BURST_MAX - 1) / BURST_MAX;
    localparam int unsigned LAST_LEN = LINE_PIX - (BPL - 1) * BURST_MAX;
    localparam int unsigned LEN_W    = $clog2(BURST_MAX + 1);
    localparam int unsigned ROW_W    = ADDR_W - COL_W;
    localparam int unsigned BIDX_W   = (BPL > 1) ? $clog2(BPL) : 1;
    localparam int unsigned CMP_W    = (FIFO_LVL_W > LEN_W) ? FIFO_LVL_W : LEN_W;

    typedef enum logic [1:0] {
        StIdle,
        StReq,
        StBurst,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic               wr_req_q, wr_req_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               flush_q, flush_d;
    logic [BIDX_W-1:0]  burst_idx_q, burst_idx_d;
    logic [ROW_W-1:0]   line_cnt_q, line_cnt_d;
    logic [1:0]         buf_q, buf_d;
    logic               frame_done_q, frame_done_d;
    logic               pend_q, pend_d;

    logic               close;
    logic [LEN_W-1:0]   need;
    logic               last_of_line;
    logic [ROW_W-1:0]   slot;
    logic [ROW_W-1:0]   row;
    logic [1:0]         buf_next;

`ifdef FIELD_INTERLEAVE_EN
    logic               pend_field_q, pend_field_d;
    logic               close_field;
`else
    logic               unused_field;
    assign unused_field = field;
`endif

    assign last_of_line = (burst_idx_q == BIDX_W'(BPL - 1));
    assign need         = last_of_line ? LEN_W'(LAST_LEN) : LEN_W'(BURST_MAX);
    assign buf_next     = (buf_q == 2'(FRAME_BUFS - 1)) ? 2'd0 : buf_q + 2'd1;

`ifdef FIELD_INTERLEAVE_EN
    assign slot = (line_cnt_q << 1) + ROW_W'(field);
`else
    assign slot = line_cnt_q;
`endif

    // Row arithmetic wraps modulo 2**ROW_W by construction.
    assign row = (ROW_W'(buf_q) << FRAME_ROW_SH) + slot * ROW_W'(BPL) + ROW_W'(burst_idx_q);

    always_comb begin
        state_d      = state_q;
        wr_req_d     = wr_req_q;
        len_d        = len_q;
        addr_d       = addr_q;
        flush_d      = flush_q;
        burst_idx_d  = burst_idx_q;
        line_cnt_d   = line_cnt_q;
        buf_d        = buf_q;
        frame_done_d = 1'b0;
        pend_d       = pend_q;
        close        = 1'b0;
`ifdef FIELD_INTERLEAVE_EN
        pend_field_d = pend_field_q;
        close_field  = field;
`endif

        unique case (state_q)
            StIdle: begin
                if (vs_neg) begin
                    close = 1'b1;
                end else if (CMP_W'(rdusedw_fifo) >= CMP_W'(need)) begin
                    state_d  = StReq;
                    wr_req_d = 1'b1;
                    len_d    = need;
                    flush_d  = 1'b0;
                    addr_d   = {row, {COL_W{1'b0}}};
                end else if (vs && (rdusedw_fifo != '0)) begin
                    // Level is below need here, so it always fits in LEN_W.
                    state_d  = StReq;
                    wr_req_d = 1'b1;
                    len_d    = LEN_W'(rdusedw_fifo);
                    flush_d  = 1'b1;
                    addr_d   = {row, {COL_W{1'b0}}};
                end
            end
            StReq: begin
                if (vs_neg) begin
                    state_d  = StIdle;
                    wr_req_d = 1'b0;
                    len_d    = '0;
                    close    = 1'b1;
                end else if (wr_port.wr_ack) begin
                    state_d  = StBurst;
                    wr_req_d = 1'b0;
                end
            end
            StBurst: begin
                // The controller is never cut mid-burst; remember vs_neg until DONE.
                if (vs_neg && !pend_q) begin
                    pend_d = 1'b1;
`ifdef FIELD_INTERLEAVE_EN
                    pend_field_d = field;
`endif
                end
                len_d = len_q - LEN_W'(1);
                if (len_q == LEN_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (!flush_q) begin
                    if (last_of_line) begin
                        burst_idx_d = '0;
                        line_cnt_d  = line_cnt_q + ROW_W'(1);
                    end else begin
                        burst_idx_d = burst_idx_q + BIDX_W'(1);
                    end
                end
                if (pend_q) begin
                    close  = 1'b1;
                    pend_d = 1'b0;
`ifdef FIELD_INTERLEAVE_EN
                    close_field = pend_field_q;
`endif
                end else if (vs_neg) begin
                    close = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

`ifdef FIELD_INTERLEAVE_EN
        // Only the odd field completes a progressive frame.
        if (close && !close_field) begin
            line_cnt_d = '0;
        end else if (close) begin
            burst_idx_d  = '0;
            line_cnt_d   = '0;
            frame_done_d = 1'b1;
            buf_d        = buf_next;
        end
`else
        if (close) begin
            burst_idx_d  = '0;
            line_cnt_d   = '0;
            frame_done_d = 1'b1;
            buf_d        = buf_next;
        end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            wr_req_q     <= 1'b0;
            len_q        <= '0;
            addr_q       <= '0;
            flush_q      <= 1'b0;
            burst_idx_q  <= '0;
            line_cnt_q   <= '0;
            buf_q        <= '0;
            frame_done_q <= 1'b0;
            pend_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_req_q     <= wr_req_d;
            len_q        <= len_d;
            addr_q       <= addr_d;
            flush_q      <= flush_d;
            burst_idx_q  <= burst_idx_d;
            line_cnt_q   <= line_cnt_d;
            buf_q        <= buf_d;
            frame_done_q <= frame_done_d;
            pend_q       <= pend_d;
        end
    end

`ifdef FIELD_INTERLEAVE_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_field_q <= 1'b0;
        end else begin
            pend_field_q <= pend_field_d;
        end
    end
`endif

    assign rd_en_fifo            = (state_q == StBurst);
    assign wr_port.wr_req        = wr_req_q;
    assign wr_port.burst_data    = indata;
    assign wr_port.burst_length  = len_q;
    assign wr_port.burst_address = addr_q;
    assign wr_buf_idx            = buf_q;
    assign frame_done            = frame_done_q;

endmodule
